lfsr_seq_ctrl: RTL

//  Sequencer for the 4-bit pseudo-random generator. Accepts a seed and a word count, then

---
 rtl/lfsr_seq_pkg.sv | 19 +
 rtl/lfsr_seq_ctrl_core.sv | 38 +++
 rtl/lfsr_seq_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/lfsr_seq_pkg.sv
// Shared types, constants and the LFSR step function for the 4-bit sequencer.
package lfsr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int          LFSR_W       = 4;
    localparam logic [3:0]  DEFAULT_TAPS = 4'b1100;

    // Shift left, feeding the parity of the tapped bits into the LSB.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                    input logic [LFSR_W-1:0] taps);
        return {s[LFSR_W-2:0], ^(s & taps)};
    endfunction

endpackage

// File: rtl/lfsr_seq_ctrl_core.sv
// LFSR register with a seed load and a single-step enable; load wins over step.
import lfsr_seq_pkg::*;

module lfsr_core #(
    parameter int                WIDTH = LFSR_W,
    parameter logic [WIDTH-1:0]  TAPS  = DEFAULT_TAPS
) (
    input  logic             clk_out,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q, TAPS);
        end
    end

    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Seeded LFSR word sequencer with command and data valid/ready handshakes.
// Define LFSR_ZERO_GUARD_EN to replace a zero seed by 1 instead of rejecting it.
import lfsr_seq_pkg::*;

module lfsr_seq_ctrl #(
    parameter int                WIDTH = LFSR_W,
    parameter int                CNT_W = 8,
    parameter logic [WIDTH-1:0]  TAPS  = DEFAULT_TAPS
) (
    input  logic             clk_out,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_seed,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_left
);

    state_e           state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             data_valid_q, data_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] words_left_q, words_left_d;

    logic             lfsr_load;
    logic             lfsr_step;
    logic [WIDTH-1:0] seed_eff;
    logic             seed_reject;

    // All-zero is the LFSR lock-up state, so it is either patched or refused.
    always_comb begin
`ifdef LFSR_ZERO_GUARD_EN
        seed_eff    = (cmd_seed == '0) ? WIDTH'(1) : cmd_seed;
        seed_reject = 1'b0;
`else
        seed_eff    = cmd_seed;
        seed_reject = (cmd_seed == '0);
`endif
    end

    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        data_valid_d = data_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        words_left_d = words_left_q;
        lfsr_load    = 1'b0;
        lfsr_step    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (seed_reject) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (cmd_count == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = RUN;
                        lfsr_load    = 1'b1;
                        data_valid_d = 1'b1;
                        busy_d       = 1'b1;
                        words_left_d = cmd_count;
                    end
                end
            end
            RUN: begin
                // Abort takes priority over a transfer in the same cycle.
                if (abort) begin
                    state_d      = IDLE;
                    cmd_ready_d  = 1'b1;
                    data_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    words_left_d = '0;
                end else if (data_valid_q && data_ready) begin
                    lfsr_step    = 1'b1;
                    words_left_d = words_left_q - CNT_W'(1);
                    if (words_left_q == CNT_W'(1)) begin
                        state_d      = DONE;
                        data_valid_d = 1'b0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d      = IDLE;
                cmd_ready_d  = 1'b1;
                data_valid_d = 1'b0;
                busy_d       = 1'b0;
                words_left_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            words_left_q <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            words_left_q <= words_left_d;
        end
    end

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clk_out (clk_out),
        .reset   (reset),
        .load    (lfsr_load),
        .step    (lfsr_step),
        .seed    (seed_eff),
        .state   (data_out)
    );

    assign cmd_ready  = cmd_ready_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign words_left = words_left_q;

endmodule
